elevator_call_scheduler: RTL and testbench
==========================================

# elevator_call_scheduler

Collects floor calls (hall and car buttons) into a pending-request bitmap and sequences the elevator controller by issuing one target floor at a time on `tgt_floor`, the controller's `req_floor` input. Uses LOOK scheduling: continue in the current direction while calls lie ahead, otherwise reverse. Times the door-open dwell at each serviced floor. Sits between the button/request logic and the `elevator` controller; the controller reports position and arrival.

## Interface
- `NUM_FLOORS`, 16: number of served floors, floors 0..NUM_FLOORS-1.
- `FLOOR_W`, 4: floor index width; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- `DOOR_CYCLES`, 8: door-open dwell in clock cycles, >= 1.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `call_valid`  in  1  one call is presented this cycle.
- `call_floor`  in  FLOOR_W  floor of the presented call.
- `cur_floor`  in  FLOOR_W  last floor reached or passed by the car, from the controller.
- `arrived`  in  1  single-cycle pulse: car has stopped at `tgt_floor`.
- `tgt_valid`  out  1  `tgt_floor` is a live command.
- `tgt_floor`  out  FLOOR_W  commanded floor; drives controller `req_floor`.
- `dir_up`  out  1  current scan direction, 1 = up.
- `door_open`  out  1  high throughout door dwell.
- `busy`  out  1  state is not IDLE.
- `pending`  out  NUM_FLOORS  outstanding call bitmap, bit i = floor i.

## Operation
- States: IDLE, MOVE, DOOR. Reset: IDLE, `pending`=0, `dir_up`=1, `tgt_valid`=0, `tgt_floor`=0, `door_open`=0, `busy`=0, door counter 0.
- Call capture, every state: `call_valid` with `call_floor` < NUM_FLOORS sets `pending[call_floor]`. Out-of-range floors are dropped. Duplicate calls are idempotent.
- "Ahead" means floors strictly above `cur_floor` when `dir_up`=1, strictly below when `dir_up`=0. "Nearest" means the smallest distance from `cur_floor`.
- IDLE, `pending`=0: remain in IDLE.
- IDLE, `pending[cur_floor]`=1: clear that bit, go to DOOR.
- IDLE, a call ahead: `tgt_floor` = nearest call ahead, go to MOVE.
- IDLE, calls only behind: toggle `dir_up`, `tgt_floor` = nearest call in the new direction, go to MOVE.
- MOVE: `tgt_valid`=1. Every cycle, `tgt_floor` is recomputed as the nearest pending call ahead. A new call between the car and the old target retargets the car. `dir_up` does not change in MOVE.
- MOVE, `arrived`=1: clear `pending[tgt_floor]`, `tgt_valid` goes to 0, go to DOOR.
- DOOR: `door_open`=1 for DOOR_CYCLES cycles, then go to IDLE. `tgt_valid`=0.
- A call to `cur_floor` during DOOR is absorbed: the bit is not set and the dwell counter restarts, extending the dwell.
- `arrived` outside MOVE is ignored.
- Same-cycle call and clear on one floor (arrival cycle): the clear wins; the call is absorbed.
- Same-cycle call and clear on different floors: both take effect.
- Reset asserted mid-MOVE or mid-DOOR: all outputs take their reset values immediately. Pending calls are lost.

## Timing
- Call to `pending` bit set: 1 cycle (visible after the next edge).
- Call into an idle scheduler to `tgt_valid`=1: 2 cycles (one edge to capture, one edge for the IDLE decision).
- Retarget in MOVE: `tgt_floor` updates 2 cycles after the call (capture, then recompute).
- `arrived` pulse to `door_open`=1 and `tgt_valid`=0: 1 cycle.
- `door_open` width: exactly DOOR_CYCLES cycles with no absorbed calls.
- DOOR to IDLE, then the next MOVE decision: 1 cycle after DOOR exits.
- Every output is a registered flop output; no combinational input-to-output paths.

## Test plan
- Reset, then call floor 6 with `cur_floor`=0 -> `pending`=0x0040, and `tgt_valid`=1 with `tgt_floor`=6 and `dir_up`=1 two cycles after the call. Pulse `arrived` -> bit 6 clears, `door_open` high for 8 cycles, scheduler returns to IDLE.
- Calls to floors 1, 5 and 3 in consecutive cycles with `cur_floor`=0 -> targets served in order 1, 3, 5, one `arrived` each, `dir_up` stays 1 throughout.
- Car moving to floor 9 with `cur_floor`=2, then call floor 4 -> `tgt_floor` becomes 4 two cycles later. After arrival and dwell, the next target is 9.
- `cur_floor`=7, `dir_up`=1, calls pending only at floors 2 and 5 -> `dir_up` goes to 0, `tgt_floor`=5, then 2.
- During DOOR at floor 3, call floor 3 -> `pending[3]` stays 0, dwell lasts DOOR_CYCLES cycles after that call. Call floor 15 with NUM_FLOORS=12 -> ignored, `pending` unchanged.
- Assert `rst` while in MOVE with 3 calls pending -> `pending`=0, `tgt_valid`=0, `busy`=0, `dir_up`=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// Purpose: LOOK-order call scheduler issuing one target floor at a time to the car controller.
// Latency: call->pending 1 cycle, idle call->tgt_valid 2 cycles, arrived->door_open 1 cycle.
// Backpressure: none; calls are always accepted (idempotent bitmap), out-of-range floors dropped.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 16,
    parameter int FLOOR_W     = 4,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrived,
    output logic                  tgt_valid,
    output logic [FLOOR_W-1:0]    tgt_floor,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  busy,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int CNT_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t                  state, state_nxt;
    logic [NUM_FLOORS-1:0]   pending_nxt, clr_vec;
    logic [FLOOR_W-1:0]      tgt_nxt, up_floor, dn_floor;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    dir_nxt, up_found, dn_found, cur_hit, call_ok, absorb;

    // Nearest call strictly above / below the car, plus a hit on the car's own floor.
    always_comb begin
        up_found = 1'b0;
        dn_found = 1'b0;
        cur_hit  = 1'b0;
        up_floor = '0;
        dn_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && i > int'(cur_floor)) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && i < int'(cur_floor)) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
            if (pending[i] && i == int'(cur_floor)) begin
                cur_hit = 1'b1;
            end
        end
    end

    assign call_ok = call_valid && (int'(call_floor) < NUM_FLOORS);

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_up;
        tgt_nxt   = tgt_floor;
        cnt_nxt   = cnt;
        clr_vec   = '0;
        absorb    = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    if (cur_hit) begin
                        clr_vec   = ONE_HOT0 << cur_floor;
                        cnt_nxt   = '0;
                        state_nxt = DOOR;
                    end else if (dir_up ? up_found : dn_found) begin
                        tgt_nxt   = dir_up ? up_floor : dn_floor;
                        state_nxt = MOVE;
                    end else begin
                        // Nothing ahead: reverse the scan.
                        dir_nxt   = ~dir_up;
                        tgt_nxt   = dir_up ? dn_floor : up_floor;
                        state_nxt = MOVE;
                    end
                end
            end
            MOVE: begin
                if (arrived) begin
                    clr_vec   = ONE_HOT0 << tgt_floor;
                    cnt_nxt   = '0;
                    state_nxt = DOOR;
                end else if (dir_up ? up_found : dn_found) begin
                    tgt_nxt = dir_up ? up_floor : dn_floor;
                end
            end
            DOOR: begin
                if (call_ok && call_floor == cur_floor) begin
                    // Passenger at the open door: extend the dwell instead of queueing.
                    absorb  = 1'b1;
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pending_nxt = pending;
        if (call_ok && !absorb) begin
            pending_nxt = pending_nxt | (ONE_HOT0 << call_floor);
        end
        pending_nxt = pending_nxt & ~clr_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            dir_up    <= 1'b1;
            tgt_floor <= '0;
            tgt_valid <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            dir_up    <= dir_nxt;
            tgt_floor <= tgt_nxt;
            tgt_valid <= (state_nxt == MOVE);
            door_open <= (state_nxt == DOOR);
            busy      <= (state_nxt != IDLE);
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Purpose: directed + random check of elevator_call_scheduler against a behavioural LOOK model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: bench emulates the car controller (position stepping and arrived pulses).
module tb_elevator_call_scheduler;

    localparam int NF = 12;
    localparam int FW = 4;
    localparam int DC = 8;
    localparam int S_IDLE = 0, S_MOVE = 1, S_DOOR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          call_valid;
    logic [FW-1:0] call_floor;
    logic [FW-1:0] cur_floor;
    logic          arrived;
    logic          tgt_valid;
    logic [FW-1:0] tgt_floor;
    logic          dir_up;
    logic          door_open;
    logic          busy;
    logic [NF-1:0] pending;

    elevator_call_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DOOR_CYCLES(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .call_valid (call_valid),
        .call_floor (call_floor),
        .cur_floor  (cur_floor),
        .arrived    (arrived),
        .tgt_valid  (tgt_valid),
        .tgt_floor  (tgt_floor),
        .dir_up     (dir_up),
        .door_open  (door_open),
        .busy       (busy),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending calls as a plain vector, door dwell as a countdown.
    int            m_state;
    logic [NF-1:0] m_pend;
    bit            m_dir;
    int            m_tgt;
    int            m_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nearest(input logic [NF-1:0] p, input int cur, input bit up);
        int best = -1;
        int bd   = 1000;
        for (int f = 0; f < NF; f++) begin
            int d = (f > cur) ? f - cur : cur - f;
            if (p[f] && (up ? f > cur : f < cur) && d < bd) begin
                best = f;
                bd   = d;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_pend  = '0;
        m_dir   = 1'b1;
        m_tgt   = 0;
        m_left  = 0;
    endtask

    task automatic model_step();
        int  cur   = int'(cur_floor);
        int  cf    = int'(call_floor);
        bit  setb  = call_valid && cf < NF;
        int  clr   = -1;
        int  a;
        logic [NF-1:0] p = m_pend;
        case (m_state)
            S_IDLE: if (p != 0) begin
                if (cur < NF && p[cur]) begin
                    clr = cur; m_state = S_DOOR; m_left = DC;
                end else begin
                    a = nearest(p, cur, m_dir);
                    if (a < 0) begin
                        m_dir = !m_dir;
                        a = nearest(p, cur, m_dir);
                    end
                    m_tgt = a; m_state = S_MOVE;
                end
            end
            S_MOVE: if (arrived) begin
                clr = m_tgt; m_state = S_DOOR; m_left = DC;
            end else begin
                a = nearest(p, cur, m_dir);
                if (a >= 0) m_tgt = a;
            end
            default: if (setb && cf == cur) begin
                setb = 1'b0; m_left = DC;
            end else begin
                m_left--;
                if (m_left == 0) m_state = S_IDLE;
            end
        endcase
        if (setb) m_pend[cf] = 1'b1;
        if (clr >= 0) m_pend[clr] = 1'b0;
    endtask

    task automatic check_all();
        check("tgt_valid", tgt_valid, m_state == S_MOVE);
        check("door_open", door_open, m_state == S_DOOR);
        check("busy", busy, m_state != S_IDLE);
        check("dir_up", dir_up, m_dir);
        check("tgt_floor", tgt_floor, m_tgt);
        check("pending", pending, m_pend);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check_all();
    endtask

    task automatic call(input int f);
        call_valid = 1'b1;
        call_floor = FW'(f);
        cycle();
        call_valid = 1'b0;
    endtask

    task automatic wait_move(input string tag);
        for (int i = 0; i < 20 && m_state != S_MOVE; i++) cycle();
        check({tag, "_reach_move"}, m_state, S_MOVE);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && m_state != S_IDLE; i++) cycle();
        check({tag, "_reach_idle"}, m_state, S_IDLE);
    endtask

    // Expect a specific target, then report arrival there.
    task automatic arrive_at(input int f, input string tag);
        wait_move(tag);
        check(tag, tgt_floor, f);
        cycle();
        cur_floor = FW'(f);
        arrived   = 1'b1;
        cycle();
        arrived   = 1'b0;
        check({tag, "_door"}, door_open, 1);
        check({tag, "_tgt_valid_off"}, tgt_valid, 0);
    endtask

    int width;
    int step_t;

    initial begin
        rst = 1'b1; call_valid = 1'b0; call_floor = '0; cur_floor = '0; arrived = 1'b0;
        model_reset();
        cycle();
        cycle();
        check("rst_pending", pending, 0);
        check("rst_dir_up", dir_up, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Single call to floor 6 from floor 0.
        call(6);
        check("s1_pending", pending, 12'h040);
        cycle();
        check("s1_tgt_valid", tgt_valid, 1);
        check("s1_tgt_floor", tgt_floor, 6);
        check("s1_dir_up", dir_up, 1);
        arrive_at(6, "s1_arrive");
        check("s1_bit_cleared", pending[6], 0);
        width = 1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!door_open) break;
            width++;
        end
        check("s1_door_width", width, DC);
        check("s1_idle", busy, 0);

        // Calls 1, 5, 3 served in ascending order.
        cur_floor = '0;
        call(1); call(5); call(3);
        arrive_at(1, "s2_first");  wait_idle("s2a");
        arrive_at(3, "s2_second"); wait_idle("s2b");
        arrive_at(5, "s2_third");  wait_idle("s2c");
        check("s2_dir_up", dir_up, 1);

        // Retarget in flight: heading to 9 from 2, call 4 appears.
        cur_floor = 4'd2;
        call(9);
        cycle();
        check("s3_tgt9", tgt_floor, 9);
        call(4);
        check("s3_still9", tgt_floor, 9);
        cycle();
        check("s3_retarget4", tgt_floor, 4);
        arrive_at(4, "s3_arrive4"); wait_idle("s3a");
        arrive_at(9, "s3_next9");

        // Reversal: calls at 2 and 5 queued during dwell, car at 7 scanning up.
        call(2); call(5);
        cur_floor = 4'd7;
        wait_idle("s4a");
        arrive_at(5, "s4_first5");
        check("s4_dir_down", dir_up, 0);
        wait_idle("s4b");
        arrive_at(2, "s4_then2");
        wait_idle("s4c");

        // Door at floor 3, same-floor call absorbed; out-of-range call dropped.
        cur_floor = 4'd3;
        call(3);
        cycle();
        check("s5_door", door_open, 1);
        cycle(); cycle();
        call(3);
        check("s5_absorbed", pending[3], 0);
        width = 1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!door_open) break;
            width++;
        end
        check("s5_extended_dwell", width, DC);
        call(15);
        check("s5_out_of_range", pending, 0);

        // Asynchronous reset mid-MOVE with three calls pending.
        cur_floor = '0;
        call(4); call(7); call(10);
        cycle();
        check("s6_pre_move", tgt_valid, 1);
        check("s6_pre_count", $countones(pending), 3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("s6_pending", pending, 0);
        check("s6_tgt_valid", tgt_valid, 0);
        check("s6_busy", busy, 0);
        check("s6_dir_up", dir_up, 1);
        cycle();
        rst = 1'b0;

        // Random calls with an emulated car that steps one floor every other cycle.
        step_t = 0;
        for (int n = 0; n < 3000; n++) begin
            arrived    = 1'b0;
            call_valid = ($urandom_range(0, 2) == 0);
            call_floor = FW'($urandom_range(0, 15));
            if (m_state == S_MOVE) begin
                step_t++;
                if (step_t >= 2) begin
                    int c = int'(cur_floor);
                    step_t = 0;
                    if (m_tgt == c + 1 || m_tgt == c - 1 || m_tgt == c) begin
                        cur_floor = FW'(m_tgt);
                        arrived   = 1'b1;
                    end else begin
                        cur_floor = (m_tgt > c) ? FW'(c + 1) : FW'(c - 1);
                    end
                end
            end else begin
                if ($urandom_range(0, 19) == 0) arrived = 1'b1;
                if (m_state == S_IDLE && $urandom_range(0, 19) == 0)
                    cur_floor = FW'($urandom_range(0, NF - 1));
            end
            cycle();
        end
        call_valid = 1'b0;
        arrived    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
